// File: rtl/lsu_data_port_pkg.sv
// Shared types for the load/store data port: opcode/funct3 encodings, FSM states,
// byte-enable constants and the latched operation record.
package lsu_data_port_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned RADR_W = 5;

  typedef logic [BE_W-1:0]   memBe_t;
  typedef logic [RADR_W-1:0] regAddr_t;

  typedef enum logic [6:0] {
    LOAD_C   = 7'b0000011,
    STORE_C  = 7'b0100011,
    OP_IMM_C = 7'b0010011,
    OP_C     = 7'b0110011
  } opcodeType_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3SType_e;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_REQ     = 2'd1,
    LSU_WAIT_RD = 2'd2,
    LSU_RESP    = 2'd3
  } lsuState_e;

  localparam memBe_t BE_BYTE = 4'b0001;
  localparam memBe_t BE_HALF = 4'b0011;
  localparam memBe_t BE_WORD = 4'b1111;

  // Word-aligned bus command held stable for the whole request phase.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    memBe_t          be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // Everything remembered about the accepted operation.
  typedef struct packed {
    logic       fault;
    logic       load;
    logic [2:0] funct3;
    logic [1:0] offset;
    regAddr_t   rd;
    mem_cmd_t   cmd;
  } lsu_op_t;

endpackage

// File: rtl/lsu_data_port_if.sv
// MEM-stage request/response and data-memory bus signals of the load/store port.
interface lsu_data_port_if;
  import lsu_data_port_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [6:0]           req_opcode;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  regAddr_t             req_rd;

  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_rdata;
  regAddr_t             rsp_rd;
  logic                 rsp_fault;

  logic                 mem_req;
  logic                 mem_we;
  logic [XLEN-1:0]      mem_addr;
  memBe_t               mem_be;
  logic [XLEN-1:0]      mem_wdata;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [XLEN-1:0]      mem_rdata;

  // The load/store unit view.
  modport slave (
    input  req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_fault,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // The pipeline plus memory view that drives the unit.
  modport master (
    output req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_fault,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_data_port_load_align.sv
// Selects the addressed byte/halfword lane of a returned memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_data_port_load_align
  import lsu_data_port_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_c_o
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin : align
    shifted  = rdata_i >> {offset_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = shifted[15:0];
    data_c_o = '0;
    case (funct3_i)
      F3_LB:   data_c_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_c_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data_c_o = rdata_i;
      F3_LBU:  data_c_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data_c_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store data port: one operation at a time, req/gnt/rvalid to data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of truncating.
module lsu_data_port
  import lsu_data_port_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  lsu_data_port_if.slave bus
);

  lsuState_e       state_q, state_d;
  lsu_op_t         op_q, op_d;
  lsu_op_t         dec;
  logic            req_ready_q, req_ready_d;
  logic            mem_req_q, mem_req_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  regAddr_t        rsp_rd_q, rsp_rd_d;
  logic            rsp_fault_q, rsp_fault_d;

  logic [1:0]      size_l2;
  logic [1:0]      offset;
  logic            legal;
  logic [XLEN-1:0] load_data_c;

  // Decode the presented request into lanes, byte enables and fault status.
  always_comb begin : decode
    size_l2 = bus.req_funct3[1:0];
    legal   = 1'b0;
    if (bus.req_opcode == LOAD_C) begin
      legal = (bus.req_funct3 != 3'b011) && (bus.req_funct3[2:1] != 2'b11);
    end else if (bus.req_opcode == STORE_C) begin
      legal = (bus.req_funct3[2] == 1'b0) && (size_l2 != 2'b11);
    end

    // Lane offset truncated to the natural alignment of the access size.
    case (size_l2)
      2'd0:    offset = bus.req_addr[1:0];
      2'd1:    offset = {bus.req_addr[1], 1'b0};
      default: offset = 2'b00;
    endcase

    dec        = '0;
    dec.load   = (bus.req_opcode == LOAD_C);
    dec.funct3 = bus.req_funct3;
    dec.offset = offset;
    dec.rd     = bus.req_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    dec.fault  = !legal || (offset != bus.req_addr[1:0]);
`else
    dec.fault  = !legal;
`endif

    if (!dec.fault) begin
      dec.cmd.we   = (bus.req_opcode == STORE_C);
      dec.cmd.addr = {bus.req_addr[XLEN-1:2], 2'b00};
      case (size_l2)
        2'd0: begin
          dec.cmd.be    = memBe_t'(BE_BYTE << offset);
          dec.cmd.wdata = {4{bus.req_wdata[7:0]}};
        end
        2'd1: begin
          dec.cmd.be    = memBe_t'(BE_HALF << offset);
          dec.cmd.wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          dec.cmd.be    = BE_WORD;
          dec.cmd.wdata = bus.req_wdata;
        end
      endcase
    end
  end

  lsu_data_port_load_align u_load_align (
    .rdata_i  (bus.mem_rdata),
    .funct3_i (op_q.funct3),
    .offset_i (op_q.offset),
    .data_c_o (load_data_c)
  );

  // Next state and next registered outputs.
  always_comb begin : next_state
    state_d     = state_q;
    op_d        = op_q;
    req_ready_d = 1'b0;
    mem_req_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_rd_d    = '0;
    rsp_fault_d = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (bus.req_valid) begin
          op_d    = dec;
          state_d = dec.fault ? LSU_RESP : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (bus.mem_gnt) begin
          state_d = op_q.load ? LSU_WAIT_RD : LSU_RESP;
        end
      end
      LSU_WAIT_RD: begin
        if (bus.mem_rvalid) begin
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    req_ready_d = (state_d == LSU_IDLE);
    mem_req_d   = (state_d == LSU_REQ);
    rsp_valid_d = (state_d == LSU_RESP);

    // Response payload is only non-zero during the completion pulse.
    if (state_d == LSU_RESP) begin
      rsp_fault_d = op_d.fault;
      rsp_rd_d    = op_d.load ? op_d.rd : '0;
      rsp_rdata_d = (state_q == LSU_WAIT_RD) ? load_data_c : '0;
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= LSU_IDLE;
      op_q        <= '0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = op_q.cmd.we;
  assign bus.mem_addr  = op_q.cmd.addr;
  assign bus.mem_be    = op_q.cmd.be;
  assign bus.mem_wdata = op_q.cmd.wdata;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: directed vector table, reset corner sequences and
// random operations checked against an arithmetic reference model.
module tb_lsu_data_port;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lsu_data_port_if bus ();

  lsu_data_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic        e_fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [4:0]  e_rd;
  } vec_t;

  task automatic chk(input string tag, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s @%0t: got %h want %h", tag, nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata,
                              input int gd, input int rvd, input logic fault,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewdata, input logic [31:0] erdata,
                              input logic [4:0] erd);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rvd;
    v.e_fault = fault; v.e_addr = eaddr; v.e_be = ebe; v.e_we = (opc == OPC_STORE);
    v.e_wdata = ewdata; v.e_rdata = erdata; v.e_rd = erd;
    return v;
  endfunction

  // Reference model: access size, natural-alignment truncation and extension by arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    bit          ld, st, legal;
    int          size, a4, off;
    logic [31:0] mask, val;
    r = v;
    ld = (v.opc == OPC_LOAD);
    st = (v.opc == OPC_STORE);
    legal = 0;
    size = 1;
    if (ld) begin
      legal = (v.f3 != 3'd3) && (v.f3 != 3'd6) && (v.f3 != 3'd7);
      size  = 1 << (int'(v.f3) % 4);
    end else if (st) begin
      legal = (v.f3 < 3'd3);
      if (legal) size = 1 << int'(v.f3);
    end
    if (!legal) size = 1;
    a4  = int'(v.addr % 4);
    off = (a4 / size) * size;
    r.e_fault = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a4 % size) != 0) r.e_fault = 1'b1;
`endif
    r.e_rd   = ld ? v.rd : 5'd0;
    r.e_we   = st;
    r.e_addr = v.addr & ~32'h3;
    r.e_be   = 4'(((1 << size) - 1) << off);
    for (int j = 0; j < 4; j++) r.e_wdata[8*j +: 8] = v.wdata[8*(j % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    val  = (v.rdata >> (8 * off)) & mask;
    if (ld && (v.f3 < 3'd4) && (size < 4) && val[8*size-1]) val = val | ~mask;
    r.e_rdata = (ld && !r.e_fault) ? val : 32'h0;
    return r;
  endfunction

  // Drives one operation from IDLE and checks every cycle until back in IDLE.
  task automatic run_op(input vec_t v, input string tag);
    bit ld;
    ld = (v.opc == OPC_LOAD) && !v.e_fault;
    chk(tag, "ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = v.opc;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    if (v.e_fault) begin
      chk(tag, "f_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk(tag, "f_rsp_fault", 32'(bus.rsp_fault), 32'd1);
      chk(tag, "f_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk(tag, "f_rsp_rd", 32'(bus.rsp_rd), 32'(v.e_rd));
      chk(tag, "f_mem_req", 32'(bus.mem_req), 32'd0);
      chk(tag, "f_ready", 32'(bus.req_ready), 32'd0);
    end else begin
      for (int i = 0; i <= v.gnt_dly; i++) begin
        chk(tag, "mem_req", 32'(bus.mem_req), 32'd1);
        chk(tag, "mem_addr", bus.mem_addr, v.e_addr);
        chk(tag, "mem_be", 32'(bus.mem_be), 32'(v.e_be));
        chk(tag, "mem_we", 32'(bus.mem_we), 32'(v.e_we));
        if (v.e_we) chk(tag, "mem_wdata", bus.mem_wdata, v.e_wdata);
        chk(tag, "ready_busy", 32'(bus.req_ready), 32'd0);
        chk(tag, "rsp_early", 32'(bus.rsp_valid), 32'd0);
        bus.mem_gnt    = (i == v.gnt_dly);
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata  = $urandom;
        @(negedge clk);
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (ld) begin
        for (int i = 0; i <= v.rv_dly; i++) begin
          chk(tag, "wait_mem_req", 32'(bus.mem_req), 32'd0);
          chk(tag, "wait_rsp", 32'(bus.rsp_valid), 32'd0);
          chk(tag, "wait_ready", 32'(bus.req_ready), 32'd0);
          bus.mem_gnt    = 1'($urandom);
          bus.mem_rvalid = (i == v.rv_dly);
          bus.mem_rdata  = (i == v.rv_dly) ? v.rdata : $urandom;
          @(negedge clk);
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
      end
      chk(tag, "rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk(tag, "rsp_fault", 32'(bus.rsp_fault), 32'd0);
      chk(tag, "rsp_rdata", bus.rsp_rdata, v.e_rdata);
      chk(tag, "rsp_rd", 32'(bus.rsp_rd), 32'(v.e_rd));
      chk(tag, "rsp_mem_req", 32'(bus.mem_req), 32'd0);
      chk(tag, "rsp_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    chk(tag, "pulse_end", 32'(bus.rsp_valid), 32'd0);
    chk(tag, "ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    vec_t vecs[$];
    vec_t v;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = '0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);

    chk("reset", "req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset", "rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset", "rsp_rd", 32'(bus.rsp_rd), 32'd0);
    chk("reset", "rsp_fault", 32'(bus.rsp_fault), 32'd0);
    chk("reset", "mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset", "mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset", "mem_addr", bus.mem_addr, 32'd0);
    chk("reset", "mem_be", 32'(bus.mem_be), 32'd0);
    chk("reset", "mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //            opc        f3    addr          wdata         rd     rdata         gd rv flt e_addr        be     e_wdata       e_rdata       e_rd
    vecs.push_back(mk(OPC_STORE, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7,  32'h0,        0, 0, 0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,        5'd0));
    vecs.push_back(mk(OPC_STORE, 3'd0, 32'h0000_0103, 32'h0000_00A5, 5'd3,  32'h0,        1, 0, 0, 32'h0000_0100, 4'h8, 32'hA5A5_A5A5, 32'h0,        5'd0));
    vecs.push_back(mk(OPC_LOAD,  3'd0, 32'h0000_0102, 32'h0,         5'd9,  32'h1280_5634, 0, 0, 0, 32'h0000_0100, 4'h4, 32'h0,        32'hFFFF_FF80, 5'd9));
    vecs.push_back(mk(OPC_LOAD,  3'd4, 32'h0000_0102, 32'h0,         5'd10, 32'h1280_5634, 0, 1, 0, 32'h0000_0100, 4'h4, 32'h0,        32'h0000_0080, 5'd10));
    vecs.push_back(mk(OPC_LOAD,  3'd1, 32'h0000_0102, 32'h0,         5'd11, 32'h1280_5634, 1, 0, 0, 32'h0000_0100, 4'hC, 32'h0,        32'h0000_1280, 5'd11));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(OPC_LOAD,  3'd2, 32'h0000_0102, 32'h0,         5'd0,  32'h1280_5634, 0, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0,        5'd0));
    vecs.push_back(mk(OPC_STORE, 3'd1, 32'h0000_0101, 32'h0000_1234, 5'd0,  32'h0,        0, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0,        5'd0));
`else
    vecs.push_back(mk(OPC_LOAD,  3'd2, 32'h0000_0102, 32'h0,         5'd0,  32'h1280_5634, 0, 0, 0, 32'h0000_0100, 4'hF, 32'h0,        32'h1280_5634, 5'd0));
    vecs.push_back(mk(OPC_STORE, 3'd1, 32'h0000_0101, 32'h0000_1234, 5'd0,  32'h0,        0, 0, 0, 32'h0000_0100, 4'h3, 32'h1234_1234, 32'h0,        5'd0));
`endif
    vecs.push_back(mk(OPC_STORE, 3'd1, 32'h0000_0206, 32'h0000_BEEF, 5'd0,  32'h0,        0, 0, 0, 32'h0000_0204, 4'hC, 32'hBEEF_BEEF, 32'h0,        5'd0));
    vecs.push_back(mk(OPC_LOAD,  3'd1, 32'h0000_0200, 32'h0,         5'd1,  32'h7FFF_8001, 0, 0, 0, 32'h0000_0200, 4'h3, 32'h0,        32'hFFFF_8001, 5'd1));
    vecs.push_back(mk(OPC_LOAD,  3'd5, 32'h0000_0202, 32'h0,         5'd2,  32'h8001_7FFF, 2, 1, 0, 32'h0000_0200, 4'hC, 32'h0,        32'h0000_8001, 5'd2));
    vecs.push_back(mk(7'h33,     3'd0, 32'h0000_0000, 32'h0,         5'd4,  32'h0,        0, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0,        5'd0));
    vecs.push_back(mk(OPC_LOAD,  3'd3, 32'h0000_0010, 32'h0,         5'd0,  32'h0,        0, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0,        5'd0));
    vecs.push_back(mk(OPC_STORE, 3'd4, 32'h0000_0010, 32'h1,         5'd0,  32'h0,        0, 0, 1, 32'h0,         4'h0, 32'h0,        32'h0,        5'd0));
    vecs.push_back(mk(OPC_LOAD,  3'd2, 32'h0000_0300, 32'h0,         5'd31, 32'hCAFE_F00D, 3, 2, 0, 32'h0000_0300, 4'hF, 32'h0,        32'hCAFE_F00D, 5'd31));
    vecs.push_back(mk(OPC_LOAD,  3'd0, 32'h0000_0007, 32'h0,         5'd6,  32'h7F00_0000, 0, 0, 0, 32'h0000_0004, 4'h8, 32'h0,        32'h0000_007F, 5'd6));
    vecs.push_back(mk(OPC_STORE, 3'd0, 32'h0000_0000, 32'hFFFF_FF12, 5'd0,  32'h0,        0, 0, 0, 32'h0000_0000, 4'h1, 32'h1212_1212, 32'h0,        5'd0));

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data; a late rvalid must not produce a response.
    bus.req_valid = 1'b1; bus.req_opcode = OPC_LOAD; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h40; bus.req_rd = 5'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_wait", "mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("rst_wait", "in_wait", 32'(bus.mem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait", "ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wait", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("rst_wait", "stale_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_wait", "stale_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("rst_wait", "stale_rsp2", 32'(bus.rsp_valid), 32'd0);

    // Reset during the request phase drops mem_req; a late grant is ignored.
    bus.req_valid = 1'b1; bus.req_opcode = OPC_STORE; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h80; bus.req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_req", "mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req", "mem_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rst_req", "ready", 32'(bus.req_ready), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("rst_req", "no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req", "no_req", 32'(bus.mem_req), 32'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 300; n++) begin
      v.opc     = ($urandom_range(0, 9) == 0) ? 7'($urandom) :
                  ($urandom_range(0, 1) == 0 ? OPC_LOAD : OPC_STORE);
      v.f3      = 3'($urandom);
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.rd      = 5'($urandom);
      v.rdata   = $urandom;
      v.gnt_dly = $urandom_range(0, 3);
      v.rv_dly  = $urandom_range(0, 3);
      v = model(v);
      run_op(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_data_port.md
# lsu_data_port

Load/store unit sitting between the MEM stage and the data memory bus: accepts one LOAD_C/STORE_C operation at a time, drives a request/grant/rvalid handshake to data memory, and returns sign- or zero-extended load data with its destination register. It is the writer/reader counterpart of the instruction-side load/store encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) in `riscv_definitions`.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM stage presents an operation.
- `req_ready` out 1: unit idle and accepting; pipeline stalls while low.
- `req_opcode` in 7: `opcodeType_e`; only LOAD_C/STORE_C legal.
- `req_funct3` in 3: `funct3ITypeLOAD_e` or `funct3SType_e` by opcode.
- `req_addr` in 32: effective byte address (rs1 + imm).
- `req_wdata` in 32: rs2 value for stores.
- `req_rd` in 5: `regAddr_t` load destination.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: `dataBus_u` extended load data; 0 for stores/faults.
- `rsp_rd` out 5: destination echoed; 0 for stores.
- `rsp_fault` out 1: misaligned/illegal access, qualified by `rsp_valid`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (word aligned, [1:0]=0), `mem_be` out 4, `mem_wdata` out 32.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: read return.

## Operation
- States: IDLE, REQ, WAIT_RD, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all req fields, compute lane/BE/fault; fault -> RESP, else -> REQ.
- REQ: `mem_req`=1, all mem outputs stable until `mem_gnt`. gnt & store -> RESP; gnt & load -> WAIT_RD.
- WAIT_RD: wait for `mem_rvalid`; capture, extract, extend -> RESP.
- RESP: `rsp_valid`=1 one cycle -> IDLE.
- Little-endian lanes: byte offset k = `addr[1:0]` occupies `[8k+7:8k]`, `mem_be[k]`.
- Stores: SB replicates byte to all lanes, BE=`0001<<k`; SH replicates halfword, BE=`0011<<k`; SW BE=`1111`.
- Loads: BE as stores, `mem_we`=0; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Fault: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0; funct3 011/110/111 load, ≥011 store; any other opcode. No bus request issued.
- `mem_rvalid` ignored outside WAIT_RD; `mem_gnt` ignored outside REQ.

## Timing
- Reset values: state IDLE, `req_ready`=1, all other outputs 0.
- Accept cycle T; earliest `mem_req` T+1; store with gnt at T+1 -> `rsp_valid` T+2.
- Load: gnt T+1, rvalid earliest T+2 -> `rsp_valid` T+3.
- Fault: `rsp_valid` at T+1, no mem activity.
- Back-to-back: next accept at cycle after RESP; `req_ready` low from T+1 through RESP.
- Reset mid-operation: immediate IDLE next edge, `mem_req` drops, pending read return discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses fault as above.
- Undefined: never faults on alignment; low address bits truncated to natural alignment (H: `addr[0]`=0, W: `addr[1:0]`=0) and access proceeds; illegal funct3/opcode still fault.

## Structure
- Add to `riscv_definitions`: `lsuState_e` enum, `memBe_t` (logic [3:0]), byte-enable constants `BE_BYTE`/`BE_HALF`/`BE_WORD`.
- One sub-module `lsu_load_align`: combinational lane select plus sign/zero extension from funct3 and offset.

## Test plan
- SW 0xDEADBEEF @0x100, gnt T+1 -> `mem_addr`=0x100, BE=1111, `mem_we`=1, `rsp_valid` T+2, fault 0.
- SB 0x000000A5 @0x103 -> BE=1000, `mem_wdata`=0xA5A5A5A5, addr 0x100.
- LB @0x102, rdata 0x12805634 -> `rsp_rdata`=0xFFFFFF80, rd echoed; LBU same -> 0x00000080; LH @0x102 -> 0x00001280.
- LW @0x102 with trap macro -> `rsp_fault`=1 at T+1, no `mem_req`; without macro -> addr 0x100, normal response.
- gnt delayed 3 cycles, rvalid 2 cycles later -> mem outputs stable, `req_ready` low throughout, single `rsp_valid`.
- `rst` asserted in WAIT_RD, then stale `mem_rvalid` -> no `rsp_valid`, `req_ready`=1.
